// File: rtl/t_pulse_gen.sv
// t_pulse_gen: conditions a raw, bouncing toggle request into one clean
// single-cycle pulse per accepted press for a downstream T flip-flop.
// The input is first passed through a two-flop synchroniser. A four-state
// debounce FSM then qualifies each level change over DB_CYCLES samples.
module t_pulse_gen #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             t,
  output logic             level,
  output logic             busy,
  output logic [CNT_W-1:0] press_cnt
);

  // Last debounce count before a qualified change is accepted.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             t_reg, t_next;
  logic             level_reg, level_next;
  logic [CNT_W-1:0] press_cnt_reg, press_cnt_next;

  // sync_reg[0] is the first (metastability-exposed) stage. sync_reg[1]
  // is the only copy of the input that the FSM is allowed to look at.
  logic [1:0] sync_reg;
  logic       s2;

  assign s2 = sync_reg[1];

  // Two-flop synchroniser for the asynchronous button line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_in};
    end
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE_LOW;
      cnt_reg       <= '0;
      t_reg         <= 1'b0;
      level_reg     <= 1'b0;
      press_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      t_reg         <= t_next;
      level_reg     <= level_next;
      press_cnt_reg <= press_cnt_next;
    end
  end

  // Next-state and output logic. The pulse defaults low, so a press can
  // only ever produce a single-cycle pulse.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    t_next         = 1'b0;
    level_next     = level_reg;
    press_cnt_next = press_cnt_reg;

    case (state_reg)
      IDLE_LOW: begin
        if (s2) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!s2) begin
          // The high run was too short: drop it as a bounce.
          state_next = IDLE_LOW;
        end else if (cnt_reg == DB_LAST) begin
          state_next     = HIGH;
          t_next         = 1'b1;
          level_next     = 1'b1;
          press_cnt_next = press_cnt_reg + CNT_W'(1);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      HIGH: begin
        if (!s2) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end

      WAIT_LOW: begin
        if (s2) begin
          // A dip while pressed is a bounce. It must not count as a new
          // press, so return to HIGH silently.
          state_next = HIGH;
        end else if (cnt_reg == DB_LAST) begin
          state_next = IDLE_LOW;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign t         = t_reg;
  assign level     = level_reg;
  assign press_cnt = press_cnt_reg;
  assign busy      = (state_reg == WAIT_HIGH) || (state_reg == WAIT_LOW);

endmodule
